modbus_rtu_req_decoder: RTL and testbench
=========================================

# modbus_rtu_req_decoder

Modbus RTU request decoder for slave mode, sitting directly downstream of `uart_bridge` and upstream of the coil/register map logic in `top_modbus_converter`. It collects the bytes of one frame between `frame_start` and `frame_end` and recomputes CRC-16. It then filters on slave address and presents one validated, field-split request (or an exception request) to the map logic over a valid/ready handshake. It also keeps saturating error counters for the CSR block.

## Interface
Parameters:
- MAX_BYTES, 8, request frame length in bytes; only 8-byte requests are supported (FC 01/02/03/04/05/06).

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  reset, asynchronous, active-low
- enable_i  in  1  slave mode enable; low aborts and holds the block in IDLE
- slave_addr_i  in  8  own station address (1..247)
- rx_data_i  in  8  byte from uart_bridge
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
- frame_start_i  in  1  one-cycle strobe, new frame begins
- frame_end_i  in  1  one-cycle strobe, inter-frame silence detected
- req_valid_o  out  1  request available
- req_ready_i  in  1  consumer accepts request
- req_fc_o  out  8  function code (byte 1)
- req_addr_o  out  16  start address {byte2, byte3}
- req_val_o  out  16  quantity or value {byte4, byte5}
- req_bcast_o  out  1  slave address was 0; no response may be sent
- req_exc_o  out  8  0x00 = none, 0x01 = illegal function, 0x03 = illegal data value
- cnt_crc_o  out  16  CRC error count, saturating
- cnt_drop_o  out  16  dropped frames (bad length, overrun), saturating
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, COLLECT, CHECK, PRESENT.
- IDLE, frame_start_i = 1:
  - clear the byte index and overflow flag, set crc = 0xFFFF, go to COLLECT.
  - rx_valid_i in the same cycle is stored as byte 0.
- IDLE, rx_valid_i without frame_start_i: ignored.
- COLLECT, each rx_valid_i:
  - if idx < 8: store byte[idx], update crc with one unrolled byte step (poly 0xA001, reflected), idx++.
  - else set overflow.
- COLLECT, frame_end_i: go to CHECK. A byte with rx_valid_i in the same cycle is included first.
- COLLECT, frame_start_i: restart collection as from IDLE (the previous partial frame is counted in cnt_drop).
- CHECK (one cycle), evaluated in this order:
  - idx != 8 or overflow → cnt_drop++, go to IDLE.
  - crc != 0x0000 (residue over all 8 bytes, CRC low byte first) → cnt_crc++, go to IDLE.
  - byte0 != slave_addr_i and byte0 != 0 → go to IDLE silently.
  - Exception evaluation:
    - FC not in {01,02,03,04,05,06} → exc 0x01.
    - FC01/02 with qty outside 1..2000 → exc 0x03.
    - FC03/04 with qty outside 1..125 → exc 0x03.
    - FC05 with value not in {0x0000, 0xFF00} → exc 0x03.
    - FC06 → never an exception.
  - byte0 == 0 (broadcast) and (FC not 05/06 or exc != 0) → go to IDLE silently.
  - Otherwise latch all req_* fields and go to PRESENT.
- PRESENT:
  - req_valid_o = 1; all req_* fields held stable until req_ready_i.
  - Transfer on the cycle where req_valid_o & req_ready_i → go to IDLE.
  - Any frame_end_i arriving while in PRESENT → cnt_drop++; its bytes are discarded.
- enable_i = 0 in any state: next state IDLE, req_valid_o = 0, counters retained.
- Counters saturate at 0xFFFF with no wrap.
- Reset values: all outputs 0, state IDLE, crc 0xFFFF, idx 0.

## Timing
- Edge on which frame_end_i is sampled = edge N. CHECK is active after N; req_valid_o rises after edge N+1.
- Counter increments are visible after edge N+1.
- Request latency from frame_end_i to req_valid_o: 2 cycles.
- With req_ready_i tied high, req_valid_o is a 1-cycle pulse. busy_o returns to 0 after edge N+2.
- The CRC update is combinational within the rx_valid_i cycle; there is no extra cycle per byte.
- Back-to-back frames: frame_start_i may arrive in CHECK and is accepted (the machine enters COLLECT instead of IDLE) if CHECK does not go to PRESENT. If CHECK goes to PRESENT, the frame is lost and counted at its frame_end_i.
- Asynchronous reset mid-frame returns to IDLE immediately and clears the counters.

## Test plan
- slave_addr 0x01, frame 01 05 00 00 FF 00 8C 3A, req_ready high → req_valid 1 cycle, 2 cycles after frame_end. Fields: fc 0x05, addr 0x0000, val 0xFF00, exc 0x00, bcast 0.
- Same frame with last byte 0x3B → no req_valid, cnt_crc = 1, cnt_drop = 0.
- Frame addressed to 0x02, valid CRC, slave_addr 0x01 → no req_valid, both counters unchanged.
- FC 0x03 with qty 0x0000, and separately 0x007E (valid CRCs) → exc 0x03 each. FC 0x2B → exc 0x01.
- 9-byte frame and 7-byte frame → cnt_drop = 2, no request. Broadcast FC 06 → req with bcast 1. Broadcast FC 03 → ignored.
- req_ready low, second valid frame sent → first request fields held, cnt_drop = 1. Then req_ready high → single transfer. enable_i low during COLLECT → IDLE, no request.

Source files
------------

// File: rtl/modbus_rtu_req_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | modbus_rtu_req_decoder: RTU slave request collect/CRC/filter/split, r1.0 |
// +--------------------------------------------------------------------------+
module modbus_rtu_req_decoder #(
  parameter int MAX_BYTES = 8
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        enable_i,
  input  logic [7:0]  slave_addr_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        frame_start_i,
  input  logic        frame_end_i,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [7:0]  req_fc_o,
  output logic [15:0] req_addr_o,
  output logic [15:0] req_val_o,
  output logic        req_bcast_o,
  output logic [7:0]  req_exc_o,
  output logic [15:0] cnt_crc_o,
  output logic [15:0] cnt_drop_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  localparam int              IDX_W      = $clog2(MAX_BYTES + 1);
  localparam int              PTR_W      = $clog2(MAX_BYTES);
  localparam logic [IDX_W-1:0] C_IDX_FULL = IDX_W'(MAX_BYTES);
  localparam logic [15:0]     C_CRC_INIT = 16'hFFFF;
  localparam logic [15:0]     C_CRC_POLY = 16'hA001;
  localparam logic [15:0]     C_CNT_MAX  = 16'hFFFF;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_buf [MAX_BYTES];
  logic [IDX_W-1:0] r_idx;
  logic             r_ovf;
  logic [15:0]      r_crc;
  logic [15:0]      r_cnt_crc, r_cnt_drop;
  logic [7:0]       r_fc, r_exc;
  logic [15:0]      r_addr, r_val;
  logic             r_bcast;

  logic        w_restart, w_collect_byte, w_drop_inc, w_crc_inc, w_latch;
  logic [7:0]  w_fc, w_exc;
  logic [15:0] w_addr, w_val;
  logic        w_bcast, w_len_bad, w_crc_bad, w_addr_miss, w_bcast_drop, w_accept;

  // One reflected CRC-16 byte step, fully unrolled so a byte costs no extra cycle
  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {8'h00, d};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ C_CRC_POLY) : (c >> 1);
    return c;
  endfunction

  assign w_fc    = r_buf[1];
  assign w_addr  = {r_buf[2], r_buf[3]};
  assign w_val   = {r_buf[4], r_buf[5]};
  assign w_bcast = (r_buf[0] == 8'h00);

  always_comb begin
    w_exc = 8'h00;
    case (w_fc)
      8'h01, 8'h02: if (w_val == 16'd0 || w_val > 16'd2000) w_exc = 8'h03;
      8'h03, 8'h04: if (w_val == 16'd0 || w_val > 16'd125) w_exc = 8'h03;
      8'h05:        if (w_val != 16'h0000 && w_val != 16'hFF00) w_exc = 8'h03;
      8'h06:        w_exc = 8'h00;
      default:      w_exc = 8'h01;
    endcase
  end

  // CRC residue over the full frame (CRC bytes included, low first) is zero when intact
  assign w_len_bad    = (r_idx != C_IDX_FULL) || r_ovf;
  assign w_crc_bad    = (r_crc != 16'h0000);
  assign w_addr_miss  = (r_buf[0] != slave_addr_i) && !w_bcast;
  assign w_bcast_drop = w_bcast && (((w_fc != 8'h05) && (w_fc != 8'h06)) || (w_exc != 8'h00));
  assign w_accept     = !w_len_bad && !w_crc_bad && !w_addr_miss && !w_bcast_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_drop_inc  = 1'b0;
    w_crc_inc   = 1'b0;
    w_latch     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (frame_start_i) begin
          w_restart   = 1'b1;
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (frame_start_i) begin
          w_restart  = 1'b1;
          w_drop_inc = 1'b1;
        end else if (frame_end_i) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
        if (w_len_bad)      w_drop_inc = 1'b1;
        else if (w_crc_bad) w_crc_inc  = 1'b1;
        else if (w_accept) begin
          w_latch     = 1'b1;
          w_state_nxt = S_PRESENT;
        end
        // A new frame starting here is only taken if nothing is being presented
        if (frame_start_i && !w_accept) begin
          w_restart   = 1'b1;
          w_state_nxt = S_COLLECT;
        end
      end
      S_PRESENT: begin
        if (req_ready_i) w_state_nxt = S_IDLE;
        if (frame_end_i) w_drop_inc  = 1'b1;
      end
    endcase
    if (!enable_i) begin
      w_state_nxt = S_IDLE;
      w_restart   = 1'b0;
      w_drop_inc  = 1'b0;
      w_crc_inc   = 1'b0;
      w_latch     = 1'b0;
    end
  end

  assign w_collect_byte = enable_i && (r_state == S_COLLECT) && rx_valid_i && !w_restart;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < MAX_BYTES; i++) r_buf[i] <= 8'h00;
      r_idx <= '0;
      r_ovf <= 1'b0;
      r_crc <= C_CRC_INIT;
    end else if (w_restart) begin
      r_ovf <= 1'b0;
      if (rx_valid_i) begin
        r_buf[0] <= rx_data_i;
        r_idx    <= IDX_W'(1);
        r_crc    <= crc_byte(C_CRC_INIT, rx_data_i);
      end else begin
        r_idx <= '0;
        r_crc <= C_CRC_INIT;
      end
    end else if (w_collect_byte) begin
      if (r_idx < C_IDX_FULL) begin
        r_buf[r_idx[PTR_W-1:0]] <= rx_data_i;
        r_idx <= r_idx + IDX_W'(1);
        r_crc <= crc_byte(r_crc, rx_data_i);
      end else begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_fc    <= 8'h00;
      r_addr  <= 16'h0000;
      r_val   <= 16'h0000;
      r_bcast <= 1'b0;
      r_exc   <= 8'h00;
    end else if (w_latch) begin
      r_fc    <= w_fc;
      r_addr  <= w_addr;
      r_val   <= w_val;
      r_bcast <= w_bcast;
      r_exc   <= w_exc;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt_crc  <= 16'h0000;
      r_cnt_drop <= 16'h0000;
    end else begin
      if (w_crc_inc && r_cnt_crc != C_CNT_MAX)   r_cnt_crc  <= r_cnt_crc + 16'd1;
      if (w_drop_inc && r_cnt_drop != C_CNT_MAX) r_cnt_drop <= r_cnt_drop + 16'd1;
    end
  end

  assign req_valid_o = (r_state == S_PRESENT) && enable_i;
  assign req_fc_o    = r_fc;
  assign req_addr_o  = r_addr;
  assign req_val_o   = r_val;
  assign req_bcast_o = r_bcast;
  assign req_exc_o   = r_exc;
  assign cnt_crc_o   = r_cnt_crc;
  assign cnt_drop_o  = r_cnt_drop;
  assign busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_modbus_rtu_req_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_modbus_rtu_req_decoder: directed self-checking bench, r1.0            |
// +--------------------------------------------------------------------------+
module tb_modbus_rtu_req_decoder;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        enable_i = 1'b1;
  logic [7:0]  slave_addr_i = 8'h01;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        frame_start_i = 1'b0;
  logic        frame_end_i = 1'b0;
  logic        req_valid_o;
  logic        req_ready_i = 1'b1;
  logic [7:0]  req_fc_o;
  logic [15:0] req_addr_o;
  logic [15:0] req_val_o;
  logic        req_bcast_o;
  logic [7:0]  req_exc_o;
  logic [15:0] cnt_crc_o;
  logic [15:0] cnt_drop_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;
  logic [7:0] fr [0:15];

  modbus_rtu_req_decoder #(.MAX_BYTES(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .enable_i(enable_i), .slave_addr_i(slave_addr_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .frame_start_i(frame_start_i),
    .frame_end_i(frame_end_i), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_fc_o(req_fc_o), .req_addr_o(req_addr_o), .req_val_o(req_val_o),
    .req_bcast_o(req_bcast_o), .req_exc_o(req_exc_o), .cnt_crc_o(cnt_crc_o),
    .cnt_drop_o(cnt_drop_o), .busy_o(busy_o)
  );

  always #5 PCLK = ~PCLK;

  // Accepted transfers, sampled mid-cycle ahead of the edge that completes them
  always @(negedge PCLK) if (PRESETn && req_valid_o && req_ready_i) n_xfer++;

  task automatic mk_frame(input logic [7:0] a, input logic [7:0] fc,
                          input logic [15:0] ad, input logic [15:0] v);
    logic [15:0] c;
    fr[0] = a; fr[1] = fc; fr[2] = ad[15:8]; fr[3] = ad[7:0]; fr[4] = v[15:8]; fr[5] = v[7:0];
    c = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      c = c ^ {8'h00, fr[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    fr[6] = c[7:0];
    fr[7] = c[15:8];
  endtask

  // Returns 1 ns after the edge that samples frame_end_i
  task automatic send_frame(input int n);
    @(posedge PCLK); #1;
    frame_start_i = 1'b1;
    @(posedge PCLK); #1;
    frame_start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_data_i = fr[i]; rx_valid_i = 1'b1;
      @(posedge PCLK); #1;
    end
    rx_valid_i = 1'b0; frame_end_i = 1'b1;
    @(posedge PCLK); #1;
    frame_end_i = 1'b0;
  endtask

  task automatic test_reset;
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    n_tests++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", req_valid_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_tests++; if ({req_fc_o, req_addr_o, req_val_o, req_exc_o, req_bcast_o} !== 49'd0) begin
      n_fail++; $display("FAIL reset_fields: got fc %h addr %h val %h exc %h bc %b want all 0",
                         req_fc_o, req_addr_o, req_val_o, req_exc_o, req_bcast_o); end
    n_tests++; if ({cnt_crc_o, cnt_drop_o} !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got crc %h drop %h want 0", cnt_crc_o, cnt_drop_o); end
    PRESETn = 1'b1;
  endtask

  task automatic test_valid_write;
    int x0;
    x0 = n_xfer;
    fr[0]=8'h01; fr[1]=8'h05; fr[2]=8'h00; fr[3]=8'h00; fr[4]=8'hFF; fr[5]=8'h00; fr[6]=8'h8C; fr[7]=8'h3A;
    send_frame(8);
    n_tests++; if ({req_valid_o, busy_o} !== 2'b01) begin n_fail++; $display("FAIL wr_check_cycle: got valid %b busy %b want 0 1", req_valid_o, busy_o); end
    @(posedge PCLK); #1;
    n_tests++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL wr_valid_rise: got %b want 1", req_valid_o); end
    n_tests++; if ({req_fc_o, req_addr_o, req_val_o, req_exc_o, req_bcast_o} !== {8'h05, 16'h0000, 16'hFF00, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL wr_fields: got fc %h addr %h val %h exc %h bc %b want 05 0000 ff00 00 0",
                         req_fc_o, req_addr_o, req_val_o, req_exc_o, req_bcast_o); end
    @(posedge PCLK); #1;
    n_tests++; if ({req_valid_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL wr_pulse_end: got valid %b busy %b want 0 0", req_valid_o, busy_o); end
    n_tests++; if (n_xfer !== x0 + 1) begin n_fail++; $display("FAIL wr_xfer_count: got %0d want %0d", n_xfer - x0, 1); end
  endtask

  task automatic test_crc_error;
    int x0;
    x0 = n_xfer;
    fr[0]=8'h01; fr[1]=8'h05; fr[2]=8'h00; fr[3]=8'h00; fr[4]=8'hFF; fr[5]=8'h00; fr[6]=8'h8C; fr[7]=8'h3B;
    send_frame(8);
    repeat (3) @(posedge PCLK);
    #1;
    n_tests++; if (cnt_crc_o !== 16'd1) begin n_fail++; $display("FAIL crc_count: got %0d want 1", cnt_crc_o); end
    n_tests++; if (cnt_drop_o !== 16'd0) begin n_fail++; $display("FAIL crc_drop: got %0d want 0", cnt_drop_o); end
    n_tests++; if (n_xfer !== x0) begin n_fail++; $display("FAIL crc_no_req: got %0d transfers want 0", n_xfer - x0); end
  endtask

  task automatic test_addr_filter;
    int x0;
    x0 = n_xfer;
    mk_frame(8'h02, 8'h06, 16'h0001, 16'h0003);
    send_frame(8);
    repeat (3) @(posedge PCLK);
    #1;
    n_tests++; if (n_xfer !== x0) begin n_fail++; $display("FAIL addr_no_req: got %0d transfers want 0", n_xfer - x0); end
    n_tests++; if ({cnt_crc_o, cnt_drop_o} !== {16'd1, 16'd0}) begin
      n_fail++; $display("FAIL addr_counters: got crc %0d drop %0d want 1 0", cnt_crc_o, cnt_drop_o); end
  endtask

  task automatic test_exceptions;
    logic [7:0]  fcs  [8] = '{8'h03, 8'h03, 8'h2B, 8'h03, 8'h01, 8'h02, 8'h05, 8'h06};
    logic [15:0] vals [8] = '{16'h0000, 16'h007E, 16'h0000, 16'h007D, 16'h07D0, 16'h07D1, 16'h1234, 16'hFFFF};
    logic [7:0]  excs [8] = '{8'h03, 8'h03, 8'h01, 8'h00, 8'h00, 8'h03, 8'h03, 8'h00};
    for (int t = 0; t < 8; t++) begin
      mk_frame(8'h01, fcs[t], 16'h0000, vals[t]);
      send_frame(8);
      @(posedge PCLK); #1;
      n_tests++;
      if ({req_valid_o, req_fc_o, req_exc_o} !== {1'b1, fcs[t], excs[t]}) begin
        n_fail++; $display("FAIL exc_case%0d: got valid %b fc %h exc %h want 1 %h %h",
                           t, req_valid_o, req_fc_o, req_exc_o, fcs[t], excs[t]); end
      @(posedge PCLK); #1;
    end
  endtask

  task automatic test_bad_length;
    int x0;
    x0 = n_xfer;
    mk_frame(8'h01, 8'h06, 16'h0001, 16'h0003);
    fr[8] = 8'h00;
    send_frame(9);
    repeat (2) @(posedge PCLK);
    #1;
    n_tests++; if (cnt_drop_o !== 16'd1) begin n_fail++; $display("FAIL len9_drop: got %0d want 1", cnt_drop_o); end
    send_frame(7);
    repeat (2) @(posedge PCLK);
    #1;
    n_tests++; if (cnt_drop_o !== 16'd2) begin n_fail++; $display("FAIL len7_drop: got %0d want 2", cnt_drop_o); end
    n_tests++; if (n_xfer !== x0) begin n_fail++; $display("FAIL len_no_req: got %0d transfers want 0", n_xfer - x0); end
  endtask

  task automatic test_broadcast;
    int x0;
    mk_frame(8'h00, 8'h06, 16'h0001, 16'h0003);
    send_frame(8);
    @(posedge PCLK); #1;
    n_tests++; if ({req_valid_o, req_bcast_o, req_fc_o, req_addr_o, req_val_o} !== {2'b11, 8'h06, 16'h0001, 16'h0003}) begin
      n_fail++; $display("FAIL bcast_fc06: got valid %b bc %b fc %h addr %h val %h want 1 1 06 0001 0003",
                         req_valid_o, req_bcast_o, req_fc_o, req_addr_o, req_val_o); end
    @(posedge PCLK); #1;
    x0 = n_xfer;
    mk_frame(8'h00, 8'h03, 16'h0000, 16'h0001);
    send_frame(8);
    repeat (3) @(posedge PCLK);
    #1;
    n_tests++; if (n_xfer !== x0) begin n_fail++; $display("FAIL bcast_fc03_ignored: got %0d transfers want 0", n_xfer - x0); end
  endtask

  task automatic test_back_to_back;
    int x0;
    req_ready_i = 1'b0;
    mk_frame(8'h01, 8'h06, 16'h0010, 16'h1234);
    send_frame(8);
    @(posedge PCLK); #1;
    n_tests++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_first_valid: got %b want 1", req_valid_o); end
    mk_frame(8'h01, 8'h06, 16'h0020, 16'h5678);
    send_frame(8);
    n_tests++; if ({req_valid_o, req_addr_o, req_val_o} !== {1'b1, 16'h0010, 16'h1234}) begin
      n_fail++; $display("FAIL hold_fields: got valid %b addr %h val %h want 1 0010 1234", req_valid_o, req_addr_o, req_val_o); end
    n_tests++; if (cnt_drop_o !== 16'd3) begin n_fail++; $display("FAIL hold_drop: got %0d want 3", cnt_drop_o); end
    x0 = n_xfer;
    req_ready_i = 1'b1;
    @(posedge PCLK); #1;
    n_tests++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b want 0", req_valid_o); end
    repeat (3) @(posedge PCLK);
    #1;
    n_tests++; if (n_xfer !== x0 + 1) begin n_fail++; $display("FAIL hold_single_xfer: got %0d want 1", n_xfer - x0); end
  endtask

  task automatic test_enable_abort;
    int x0;
    x0 = n_xfer;
    mk_frame(8'h01, 8'h06, 16'h0002, 16'h0004);
    @(posedge PCLK); #1;
    frame_start_i = 1'b1;
    @(posedge PCLK); #1;
    frame_start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx_data_i = fr[i]; rx_valid_i = 1'b1;
      enable_i = (i != 3);
      @(posedge PCLK); #1;
      if (i == 3) begin
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL en_abort_idle: got busy %b want 0", busy_o); end
      end
    end
    enable_i = 1'b1;
    rx_valid_i = 1'b0; frame_end_i = 1'b1;
    @(posedge PCLK); #1;
    frame_end_i = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    n_tests++; if (n_xfer !== x0) begin n_fail++; $display("FAIL en_no_req: got %0d transfers want 0", n_xfer - x0); end
    n_tests++; if ({cnt_crc_o, cnt_drop_o} !== {16'd1, 16'd3}) begin
      n_fail++; $display("FAIL en_counters: got crc %0d drop %0d want 1 3", cnt_crc_o, cnt_drop_o); end
  endtask

  task automatic test_async_reset;
    mk_frame(8'h01, 8'h06, 16'h0002, 16'h0004);
    @(posedge PCLK); #1;
    frame_start_i = 1'b1;
    @(posedge PCLK); #1;
    frame_start_i = 1'b0;
    rx_data_i = fr[0]; rx_valid_i = 1'b1;
    @(posedge PCLK); #1;
    rx_valid_i = 1'b0;
    #2;
    PRESETn = 1'b0;
    #1;
    n_tests++; if ({busy_o, cnt_crc_o, cnt_drop_o} !== 33'd0) begin
      n_fail++; $display("FAIL async_reset: got busy %b crc %0d drop %0d want 0 0 0", busy_o, cnt_crc_o, cnt_drop_o); end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_valid_write();
    test_crc_error();
    test_addr_filter();
    test_exceptions();
    test_bad_length();
    test_broadcast();
    test_back_to_back();
    test_enable_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
